serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor: computes diff = a - b - bin one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow. It is the inverse-operation counterpart to the combinational full-adder cell and serves as the area-cheap subtract path for multi-cycle datapaths. Operands are captured on a start pulse; the result is presented with a one-cycle done pulse and held until the next operation.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend, captured when start is accepted
b  input  WIDTH  subtrahend, captured when start is accepted
bin  input  1  borrow-in, captured when start is accepted
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: diff/bout valid
diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH
bout  output  1  borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift registers, bit counter and borrow cleared.
- Reset has priority over all other inputs, including mid-operation: the operation is abandoned, no done pulse is produced, and outputs return to reset values.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> load a, b into shift registers, borrow <= bin, count <= 0, go RUN. start=0 -> stay in IDLE.
  - RUN: each cycle processes bit count.
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
    - d shifts into the result register from the MSB side; operand registers shift right; count increments.
    - When count = WIDTH-1, go DONE.
  - DONE: lasts exactly one cycle. start=1 -> accepted, same action as IDLE (back-to-back ops). Else -> IDLE.
- Outputs:
  - busy = 1 in RUN only.
  - done = 1 in DONE only.
  - diff and bout update on entry to DONE and hold through IDLE until the next DONE. They are not updated bit-by-bit.
- Latency: start accepted at edge E0 -> busy high for WIDTH cycles -> done high in cycle WIDTH+1 after E0. Throughput is one op per WIDTH+1 cycles.
- start while busy=1: ignored, with no effect on operands or timing. a/b/bin may change freely after capture.
- Arithmetic: diff = (a - b - bin) mod 2^WIDTH. bout = 1 exactly when a < b + bin as unsigned, i.e. the final borrow. bin is 1 bit only.
- Counter width: clog2(WIDTH) bits; no wrap-around beyond WIDTH-1.

Test Plan:
- WIDTH=8: a=0x5A, b=0x3C, bin=0, start one cycle -> busy for 8 cycles, then done 1 cycle, diff=0x1E, bout=0; diff holds after done falls.
- a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1 (borrow ripples through all bits).
- a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0. Then a=0x80, b=0x01, bin=1 -> diff=0x7E, bout=0.
- start held high continuously with changing a/b -> pulses in RUN are ignored; a new op starts in each DONE cycle; period exactly 9 cycles; each result matches the operands captured at its start.
- rst=1 on the 4th RUN cycle of a=0x5A, b=0x3C -> next cycle busy=0, done=0, diff=0x00, bout=0, and no done pulse follows. A new start then completes normally with diff=0x1E.
- Directed sweep over a, b in {0x00, 0x01, 0x7F, 0x80, 0xFE, 0xFF} x bin in {0, 1} -> every {bout, diff} equals the reference 9-bit result of a - b - bin.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first, through a
// single full-subtractor cell with a registered borrow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Holds the first WIDTH-1 result bits; the final bit is merged in on entry to StDone.
  logic [WIDTH-2:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             a0, b0, d_bit, br_next;
  logic [WIDTH-1:0] res_full;

  // Full-subtractor cell.
  always_comb begin
    a0       = a_sr_q[0];
    b0       = b_sr_q[0];
    d_bit    = a0 ^ b0 ^ br_q;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    res_full = {d_bit, res_q};
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = res_full[WIDTH-1:1];
        br_d   = br_next;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          diff_d  = res_full;
          bout_d  = br_next;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed, sweep, back-to-back, reset and
// random operations against an integer-arithmetic reference.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         bout;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: {borrow, diff} from plain signed integer subtraction.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    int r;
    logic [31:0] rv;
    r  = int'(x) - int'(y) - int'(bi);
    rv = r;
    return {r < 0, rv[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with cycle-exact latency checks; all drives happen #1 after a rising edge.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] exp;
    exp   = ref_sub(x, y, bi);
    a     = x;
    b     = y;
    bin   = bi;
    start = 1'b1;
    tick();
    for (int i = 0; i < int'(W); i++) begin
      check("busy_run", busy, 1'b1);
      check("done_run", done, 1'b0);
      start = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      tick();
    end
    start = 1'b0;
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("diff", diff, exp[W-1:0]);
    check("bout", bout, exp[W]);
    tick();
    check("done_fall", done, 1'b0);
    check("diff_hold", diff, exp[W-1:0]);
    check("bout_hold", bout, exp[W]);
  endtask

  logic [W-1:0] corner [6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};

  initial begin
    logic [W-1:0] qa [4];
    logic [W-1:0] qb [4];
    logic         qi [4];
    logic [W:0]   exp;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_bout", bout, 1'b0);
    rst = 1'b0;
    tick();

    // Directed cases.
    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'h10, 8'h20, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h80, 8'h01, 1'b1);

    // Back-to-back with start held high; operands change every cycle.
    for (int m = 0; m < 4; m++) begin
      qa[m] = W'($urandom);
      qb[m] = W'($urandom);
      qi[m] = 1'($urandom);
    end
    a     = qa[0];
    b     = qb[0];
    bin   = qi[0];
    start = 1'b1;
    tick();
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < int'(W); i++) begin
        check("b2b_busy", busy, 1'b1);
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
        tick();
      end
      exp = ref_sub(qa[m], qb[m], qi[m]);
      check("b2b_done", done, 1'b1);
      check("b2b_diff", diff, exp[W-1:0]);
      check("b2b_bout", bout, exp[W]);
      if (m < 3) begin
        a   = qa[m+1];
        b   = qb[m+1];
        bin = qi[m+1];
      end else begin
        start = 1'b0;
      end
      tick();
    end
    tick();

    // Reset during the 4th RUN cycle abandons the operation.
    a     = 8'h5A;
    b     = 8'h3C;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_diff", diff, 8'h00);
    check("mid_rst_bout", bout, 1'b0);
    for (int i = 0; i < int'(W) + 2; i++) begin
      check("no_done_after_rst", done, 1'b0);
      tick();
    end
    run_op(8'h5A, 8'h3C, 1'b0);

    // Corner sweep.
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int k = 0; k < 2; k++)
          run_op(corner[i], corner[j], 1'(k));

    // Random operations with idle gaps; results must hold while idle.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic         ri;
      int           gap;
      ra  = W'($urandom);
      rb  = W'($urandom);
      ri  = 1'($urandom);
      exp = ref_sub(ra, rb, ri);
      run_op(ra, rb, ri);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        a = W'($urandom);
        b = W'($urandom);
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_diff", diff, exp[W-1:0]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
